// File: rtl/seg_pkg.sv
// Shared types, segment constants and helpers for the multiplexed 7-segment controller.
// Segment vectors are active-low with bit 0 = a ... bit 6 = g.
package seg_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {StIdle, StRun} conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // ceil(w * log10(2)), using 0.30103 scaled by 1e5; w*0.30103 is never integral for 4..32.
  function automatic int unsigned nbcd(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [6:0] hex2seg(input digit_t d);
    logic [6:0] seg;
    case (d)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one adjust+shift step per clock.
// The final result is presented on bcd in the same cycle done is high.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [W-1:0]           bin,
  output logic [4*nbcd(W)-1:0]   bcd,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NB = nbcd(W);
  localparam int unsigned BW = 4 * NB;
  localparam int unsigned CW = $clog2(W + 1);

  conv_state_e   state_q, state_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StRun) && last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(NB); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      if (start) begin
        bin_d = bin;
        bcd_d = '0;
        cnt_d = '0;
      end
    end else begin
      bcd_d = {bcd_adj[BW-2:0], bin_q[W-1]};
      bin_d = {bin_q[W-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bcd = bcd_d;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment controller with hex/decimal display,
// leading-zero blanking, per-digit decimal points and overflow dashes.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  parameter int unsigned W    = 16,
  parameter int unsigned N    = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    din,
  input  logic            load,
  input  logic            mode,
  input  logic            blank_lz,
  input  logic [NDIG-1:0] dp,
  output logic            busy,
  output logic [6:0]      sal,
  output logic            dpo,
  output logic [NDIG-1:0] an
);

  localparam int unsigned NB = nbcd(W);
  localparam int unsigned BW = 4 * NB;
  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic          conv_busy, conv_done;
  logic [BW-1:0] conv_bcd;
  logic          accept, start_dec;

  logic [DW-1:0] hex_digits, dec_digits;
  logic          hex_ovf, dec_ovf;

  logic [DW-1:0] disp_q;
  logic          ovf_q;

  logic [N-1:0]  pre_q;
  logic [IW-1:0] idx_q, idx_d;

  digit_t          cur_digit;
  logic            cur_dp, nonzero_above, blanked;
  logic [6:0]      sal_d, sal_q;
  logic            dpo_d, dpo_q;
  logic [NDIG-1:0] an_d, an_q;

  assign accept    = load && !conv_busy;
  assign start_dec = accept && mode;
  assign busy      = conv_busy;

  seg_bin2bcd #(
    .W (W)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_dec),
    .bin   (din),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // Bits beyond the displayable digits only feed the overflow flag.
  always_comb begin
    hex_digits = '0;
    hex_ovf    = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (i < int'(DW)) hex_digits[i] = din[i];
      else              hex_ovf       = hex_ovf | din[i];
    end
  end

  always_comb begin
    dec_digits = '0;
    dec_ovf    = 1'b0;
    for (int i = 0; i < int'(BW); i++) begin
      if (i < int'(DW)) dec_digits[i] = conv_bcd[i];
      else              dec_ovf       = dec_ovf | conv_bcd[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (accept && !mode) begin
      disp_q <= hex_digits;
      ovf_q  <= hex_ovf;
    end else if (conv_done) begin
      disp_q <= dec_digits;
      ovf_q  <= dec_ovf;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (&pre_q) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_q + N'(1);
      idx_q <= idx_d;
    end
  end

  always_comb begin
    cur_digit     = '0;
    cur_dp        = 1'b0;
    nonzero_above = 1'b0;
    an_d          = '1;
    for (int d = 0; d < int'(NDIG); d++) begin
      if (idx_q == IW'(d)) begin
        cur_digit = disp_q[4*d +: 4];
        cur_dp    = dp[d];
        an_d[d]   = 1'b0;
      end
      if ((IW'(d) >= idx_q) && (disp_q[4*d +: 4] != 4'h0)) nonzero_above = 1'b1;
    end
  end

  // Digit 0 is never blanked so a zero value still shows a single "0".
  always_comb begin
    blanked = blank_lz && (idx_q != '0) && !nonzero_above && !ovf_q;
    if (ovf_q)        sal_d = SEG_DASH;
    else if (blanked) sal_d = SEG_BLANK;
    else              sal_d = hex2seg(cur_digit);
    dpo_d = blanked ? 1'b1 : ~cur_dp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sal_q <= SEG_BLANK;
      dpo_q <= 1'b1;
      an_q  <= '1;
    end else begin
      sal_q <= sal_d;
      dpo_q <= dpo_d;
      an_q  <= an_d;
    end
  end

  assign sal = sal_q;
  assign dpo = dpo_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, W=16, N=2): table-driven display vectors
// plus hand-written sequences for scan timing, busy length, ignored loads and mid-conversion reset.
module tb_seg_scan_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned N    = 2;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-1:0]    din;
  logic            load;
  logic            mode;
  logic            blank_lz;
  logic [NDIG-1:0] dp;
  logic            busy;
  logic [6:0]      sal;
  logic            dpo;
  logic [NDIG-1:0] an;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NDIG (NDIG),
    .W    (W),
    .N    (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .dp       (dp),
    .busy     (busy),
    .sal      (sal),
    .dpo      (dpo),
    .an       (an)
  );

  // sal packs digit 3..0 glyphs from MSB down; dpo is the expected pin per digit.
  typedef struct packed {
    logic [15:0] din;
    logic        mode;
    logic        blz;
    logic [3:0]  dp;
    logic [27:0] sal;
    logic [3:0]  dpo;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic m);
    @(negedge clk);
    din  = v;
    mode = m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // One full refresh, checking whichever digit is lit at each sample.
  task automatic scan_check(input string name, input logic [27:0] es, input logic [3:0] ed);
    for (int c = 0; c < 16; c++) begin
      int k;
      @(negedge clk);
      k = -1;
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) k = i;
      if (k < 0) begin
        check({name, "_an"}, {28'b0, an}, 32'he);
      end else begin
        check({name, "_sal"}, {25'b0, sal}, {25'b0, es[7*k +: 7]});
        check({name, "_dpo"}, {31'b0, dpo}, {31'b0, ed[k]});
      end
    end
  endtask

  initial begin
    int n;
    int falls;
    logic prev;

    vecs[0]  = '{16'h00F0, 1'b0, 1'b0, 4'b0000, {G0, G0, GF, G0}, 4'b1111};
    vecs[1]  = '{16'h00F0, 1'b0, 1'b1, 4'b0000, {BL, BL, GF, G0}, 4'b1111};
    vecs[2]  = '{16'd240,  1'b1, 1'b0, 4'b0000, {G0, G2, G4, G0}, 4'b1111};
    vecs[3]  = '{16'd240,  1'b1, 1'b1, 4'b0000, {BL, G2, G4, G0}, 4'b1111};
    vecs[4]  = '{16'd9999, 1'b1, 1'b1, 4'b0000, {G9, G9, G9, G9}, 4'b1111};
    vecs[5]  = '{16'd10000, 1'b1, 1'b1, 4'b0001, {DS, DS, DS, DS}, 4'b1110};
    vecs[6]  = '{16'h0000, 1'b0, 1'b1, 4'b0100, {BL, BL, BL, G0}, 4'b1111};
    vecs[7]  = '{16'h0000, 1'b0, 1'b0, 4'b0100, {G0, G0, G0, G0}, 4'b1011};
    vecs[8]  = '{16'hABCD, 1'b0, 1'b0, 4'b1010, {GA, GB, GC, GD}, 4'b0101};
    vecs[9]  = '{16'h0100, 1'b0, 1'b1, 4'b1111, {BL, G1, G0, G0}, 4'b1000};
    vecs[10] = '{16'd65535, 1'b1, 1'b0, 4'b0000, {DS, DS, DS, DS}, 4'b1111};
    vecs[11] = '{16'd0,    1'b1, 1'b1, 4'b0000, {BL, BL, BL, G0}, 4'b1111};

    reset    = 1'b1;
    din      = '0;
    load     = 1'b0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    dp       = '0;
    #1 reset = 1'b0;
    #11;
    check("rst_sal",  {25'b0, sal}, 32'h7f);
    check("rst_dpo",  {31'b0, dpo}, 32'h1);
    check("rst_an",   {28'b0, an},  32'hf);
    check("rst_busy", {31'b0, busy}, 32'h0);

    // Release at a falling edge; the next rising edge is edge 1.
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      logic [3:0] exp_an;
      @(negedge clk);
      exp_an = ~(4'b0001 << (((e - 1) / 4) % 4));
      check("scan_an",  {28'b0, an},  {28'b0, exp_an});
      check("scan_sal", {25'b0, sal}, {25'b0, G0});
    end

    for (int v = 0; v < 12; v++) begin
      blank_lz = vecs[v].blz;
      dp       = vecs[v].dp;
      wait_idle();
      do_load(vecs[v].din, vecs[v].mode);
      wait_idle();
      repeat (2) @(negedge clk);
      scan_check($sformatf("vec%0d", v), vecs[v].sal, vecs[v].dpo);
    end

    // busy length for a decimal load
    blank_lz = 1'b0;
    dp       = '0;
    wait_idle();
    do_load(16'd240, 1'b1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("busy_len", n, 32'd16);

    // second load during conversion must be ignored
    wait_idle();
    do_load(16'd1234, 1'b1);
    repeat (2) @(negedge clk);
    din  = 16'd5678;
    load = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    prev  = busy;
    falls = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (prev && !busy) falls++;
      prev = busy;
    end
    check("busy_falls", falls, 32'd1);
    wait_idle();
    repeat (2) @(negedge clk);
    scan_check("ignored_load", {G1, G2, G3, G4}, 4'b1111);

    // reset part-way through a conversion
    wait_idle();
    do_load(16'd9999, 1'b1);
    wait_idle();
    do_load(16'd240, 1'b1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_sal",  {25'b0, sal}, 32'h7f);
    check("midrst_dpo",  {31'b0, dpo}, 32'h1);
    check("midrst_an",   {28'b0, an},  32'hf);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_an", {28'b0, an}, 32'he);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check("post_rst_sal", {25'b0, sal}, {25'b0, G0});
    end
    check("post_rst_busy", {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
